// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst master and its read skid buffer.
package ram_burst_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} burst_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry read-data skid FIFO with a combinational bypass when empty and a
// synchronous flush that also serves as its reset.
module ram_rd_skid
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] pushData_i,
  output logic                  outValid_o,
  input  logic                  outReady_i,
  output logic [DATA_WIDTH-1:0] outData_o,
  output logic [SKID_CNT_W-1:0] count_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] rdPtr_q;
  logic [SKID_PTR_W-1:0] wrPtr_q;
  logic [SKID_CNT_W-1:0] count_q;
  logic                  empty;
  logic                  doWrite;
  logic                  doRead;

  // An empty buffer forwards the incoming beat so the stream keeps full rate.
  assign empty      = (count_q == '0);
  assign outValid_o = !empty || push_i;
  assign outData_o  = empty ? pushData_i : mem_q[rdPtr_q];
  assign count_o    = count_q;
  assign doWrite    = push_i && !(empty && outReady_i);
  assign doRead     = outReady_i && !empty;

  always_ff @(posedge clk) begin
    if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + SKID_PTR_W'(1);
      end
      if (doRead) begin
        rdPtr_q <= rdPtr_q + SKID_PTR_W'(1);
      end
      count_q <= count_q + SKID_CNT_W'(doWrite) - SKID_CNT_W'(doRead);
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst read/write initiator for the single-port synchronous RAM.
// Optional RAM_BURST_MASTER_BOUND_EN rejects bursts that would cross the top of memory.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ram_en,
  output logic                  ram_wr_rdn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_rd
);

  burst_state_e          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  lenLeft_q;
  logic [LEN_WIDTH:0]    issLeft_q;
  logic                  inFlight_q;

  logic                  cmdFire;
  logic                  wrFire;
  logic                  rdIssue;
  logic                  rdPop;
  logic                  outOfBound;
  logic                  skidValid;
  logic [DATA_WIDTH-1:0] skidData;
  logic [SKID_CNT_W-1:0] skidCount;

  assign cmdFire = cmd_valid && cmd_ready;
  assign wrFire  = wdata_valid && wdata_ready;
  assign rdPop   = rdata_valid && rdata_ready;

  // Reads are issued only while the skid buffer can absorb every outstanding beat.
  assign rdIssue = (state_q == READ) && (issLeft_q != '0) &&
                   ((int'(skidCount) + int'(inFlight_q)) < SKID_DEPTH);

`ifdef RAM_BURST_MASTER_BOUND_EN
  localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;
  localparam logic [SUM_W-1:0] ADDR_MAX = SUM_W'({ADDR_WIDTH{1'b1}});

  logic [SUM_W-1:0] burstEnd;
  logic             err_q;

  assign burstEnd   = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign outOfBound = (burstEnd > ADDR_MAX);
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cmdFire && outOfBound;
    end
  end
`else
  assign outOfBound = 1'b0;
  assign err        = 1'b0;
`endif

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  // RAM strobes are combinational so a write beat lands in the cycle it is offered.
  assign ram_en      = !rst && (((state_q == WRITE) && wdata_valid) || rdIssue);
  assign ram_wr_rdn  = (state_q == WRITE);
  assign ram_addr    = ((state_q == WRITE) || (state_q == READ)) ? addr_q : '0;
  assign ram_data_wr = (state_q == WRITE) ? wdata : '0;

  assign rdata_valid = (state_q == READ) && skidValid;
  assign rdata       = rdata_valid ? skidData : '0;

  ram_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uSkid (
    .clk       (clk),
    .flush_i   (rst),
    .push_i    (inFlight_q),
    .pushData_i(ram_data_rd),
    .outValid_o(skidValid),
    .outReady_i(rdata_ready && (state_q == READ)),
    .outData_o (skidData),
    .count_o   (skidCount)
  );

  // Burst sequencing: write beats and read pops both count down the same beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lenLeft_q  <= '0;
      issLeft_q  <= '0;
      inFlight_q <= 1'b0;
    end else begin
      inFlight_q <= rdIssue;
      case (state_q)
        IDLE: begin
          if (cmdFire) begin
            addr_q    <= cmd_addr;
            lenLeft_q <= cmd_len;
            issLeft_q <= {1'b0, cmd_len} + (LEN_WIDTH + 1)'(1);
            if (outOfBound) begin
              state_q <= DONE;
            end else if (cmd_wr) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        WRITE: begin
          if (wrFire) begin
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            lenLeft_q <= lenLeft_q - LEN_WIDTH'(1);
            if (lenLeft_q == '0) begin
              state_q <= DONE;
            end
          end
        end
        READ: begin
          if (rdIssue) begin
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            issLeft_q <= issLeft_q - (LEN_WIDTH + 1)'(1);
          end
          if (rdPop) begin
            lenLeft_q <= lenLeft_q - LEN_WIDTH'(1);
            if (lenLeft_q == '0) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a RAM model, a reference memory and
// a per-cycle scoreboard; RAM_BURST_MASTER_BOUND_EN selects the bound-check expectations.
module tb_ram_burst_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        ram_en;
  logic        ram_wr_rdn;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data_wr;
  logic [31:0] ram_data_rd;

  int vecCount  = 0;
  int missCount = 0;

  logic [31:0] ramMem [1024];
  logic [31:0] refMem [1024];
  logic [31:0] wrData [16];
  int          cmdAddrM;
  int          wrIdx;
  int          rdIss;
  int          rdPop;
  logic        readActive;

  ram_burst_master dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ram_en     (ram_en),
    .ram_wr_rdn (ram_wr_rdn),
    .ram_addr   (ram_addr),
    .ram_data_wr(ram_data_wr),
    .ram_data_rd(ram_data_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The RAM itself: one-cycle read latency, write on the strobe edge.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr_rdn) begin
        ramMem[ram_addr] <= ram_data_wr;
      end else begin
        ram_data_rd <= ramMem[ram_addr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount = vecCount + 1;
    if (act !== exp) begin
      missCount = missCount + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe and every accepted read beat is checked against the
  // addresses and data the bench intended, independent of how the DUT sequences them.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en && ram_wr_rdn) begin
        checkOutput("sb_wr_addr", {22'd0, ram_addr}, (cmdAddrM + wrIdx) & 32'h3FF);
        checkOutput("sb_wr_data", ram_data_wr, wrData[wrIdx & 15]);
        refMem[(cmdAddrM + wrIdx) & 32'h3FF] = wrData[wrIdx & 15];
        wrIdx = wrIdx + 1;
      end
      if (ram_en && !ram_wr_rdn) begin
        checkOutput("sb_rd_addr", {22'd0, ram_addr}, (cmdAddrM + rdIss) & 32'h3FF);
        rdIss = rdIss + 1;
      end
      if (rdata_valid && rdata_ready) begin
        checkOutput("sb_rd_data", rdata, refMem[(cmdAddrM + rdPop) & 32'h3FF]);
        rdPop = rdPop + 1;
      end
      if (readActive) begin
        checkOutput("sb_outstanding_le_2", {31'd0, (rdIss - rdPop) <= 2}, 32'd1);
      end
    end
  end

  // Offers one command and returns 1 ns into the cycle after the handshake.
  task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [7:0] len);
    @(posedge clk);
    #1;
    cmdAddrM   = int'(addr);
    wrIdx      = 0;
    rdIss      = 0;
    rdPop      = 0;
    readActive = !wr;
    cmd_valid  = 1'b1;
    cmd_wr     = wr;
    cmd_addr   = addr;
    cmd_len    = len;
    @(negedge clk);
    checkOutput("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic writeBurst(input logic [9:0] addr, input int beats, input logic [31:0] base);
    for (int k = 0; k < beats; k++) begin
      wrData[k] = base + k;
    end
    for (int k = 0; k < beats; k++) begin
      wdata_valid = 1'b1;
      wdata       = wrData[k];
      @(negedge clk);
      checkOutput("wr_en", {31'd0, ram_en}, 32'd1);
      checkOutput("wr_dir", {31'd0, ram_wr_rdn}, 32'd1);
      checkOutput("wr_addr", {22'd0, ram_addr}, (int'(addr) + k) & 32'h3FF);
      @(posedge clk);
      #1;
    end
    wdata_valid = 1'b0;
    @(negedge clk);
    checkOutput("wr_done", {31'd0, done}, 32'd1);
    checkOutput("wr_done_en", {31'd0, ram_en}, 32'd0);
    @(negedge clk);
    checkOutput("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic readBurst(input logic [3:0] pattern, input int beats);
    int got = 0;
    int c   = 0;
    while (got < beats && c < 60) begin
      rdata_ready = pattern[c % 4];
      @(negedge clk);
      if (rdata_valid && rdata_ready) got++;
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("rd_beat_count", got, beats);
    rdata_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ramMem[i] = 32'd0;
      refMem[i] = 32'd0;
    end
    cmdAddrM    = 0;
    wrIdx       = 0;
    rdIss       = 0;
    rdPop       = 0;
    readActive  = 1'b0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    rdata_ready = 1'b0;
    ram_data_rd = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    checkOutput("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_ram_en", {31'd0, ram_en}, 32'd0);
    checkOutput("rst_ram_wr_rdn", {31'd0, ram_wr_rdn}, 32'd0);
    checkOutput("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    checkOutput("rst_ram_data_wr", ram_data_wr, 32'd0);

    // Write 0xA0..0xA3 to 0x010..0x013.
    applyStimulus(1'b1, 10'h010, 8'd3);
    writeBurst(10'h010, 4, 32'hA0);

    // Full-rate read back with literal timing.
    applyStimulus(1'b0, 10'h010, 8'd3);
    rdata_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd_t1_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("rd_t1_en", {31'd0, ram_en}, 32'd1);
    checkOutput("rd_t1_dir", {31'd0, ram_wr_rdn}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rd_full_valid", {31'd0, rdata_valid}, 32'd1);
      checkOutput("rd_full_data", rdata, 32'hA0 + k);
    end
    @(negedge clk);
    checkOutput("rd_full_done", {31'd0, done}, 32'd1);

    // Same read under 1,0,1,0 backpressure.
    applyStimulus(1'b0, 10'h010, 8'd3);
    readBurst(4'b0101, 4);

    // Burst crossing the top of memory.
    applyStimulus(1'b1, 10'h3FE, 8'd3);
`ifdef RAM_BURST_MASTER_BOUND_EN
    wdata_valid = 1'b1;
    wdata       = 32'hDEAD;
    @(negedge clk);
    checkOutput("bound_err", {31'd0, err}, 32'd1);
    checkOutput("bound_done", {31'd0, done}, 32'd1);
    checkOutput("bound_ram_en", {31'd0, ram_en}, 32'd0);
    checkOutput("bound_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    @(negedge clk);
    checkOutput("bound_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("bound_err_clear", {31'd0, err}, 32'd0);
    wdata_valid = 1'b0;
`else
    writeBurst(10'h3FE, 4, 32'hB0);
    applyStimulus(1'b0, 10'h3FE, 8'd3);
    rdata_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_rd_first", rdata, 32'hB0);
    readBurst(4'b1111, 3);
`endif

    // Reset in the middle of a read after two beats.
    applyStimulus(1'b0, 10'h010, 8'd3);
    rdata_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_en_in_rst", {31'd0, ram_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("midrst_ram_en", {31'd0, ram_en}, 32'd0);
    checkOutput("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // A fresh read after the reset returns the stored data.
    applyStimulus(1'b0, 10'h011, 8'd2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_rst_first", rdata, 32'hA1);
    readBurst(4'b1111, 2);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator for the team's single-port synchronous RAM. It accepts burst read/write commands on a valid/ready command channel and streams write data in on one valid/ready channel and read data out on another. It drives the RAM's en/wr_rdn/addr/data_wr port and absorbs the RAM's one-cycle read latency, so the read stream runs at full rate under backpressure. It sits between a DMA/CPU-side agent and one RAM instance.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM address width (1024 words)
- LEN_WIDTH, 8, burst length field width; a command carries beats-1
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_wr  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  ADDR_WIDTH  start word address
- cmd_len  input  LEN_WIDTH  beats-1
- wdata_valid  input  1  write beat offered
- wdata_ready  output  1  high only in WRITE
- wdata  input  DATA_WIDTH  write beat
- rdata_valid  output  1  read beat available
- rdata_ready  input  1  consumer accepts
- rdata  output  DATA_WIDTH  read beat
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at burst completion
- err  output  1  one-cycle pulse on rejected command (macro only; tied 0 otherwise)
- ram_en, ram_wr_rdn  output  1 each  RAM strobe and direction
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_data_wr  output  DATA_WIDTH  RAM write data
- ram_data_rd  input  DATA_WIDTH  RAM read data, valid the cycle after a read strobe

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: a cmd_valid&&cmd_ready handshake latches the address counter (cmd_addr) and the beat counter (cmd_len), then moves to WRITE or READ per cmd_wr.
- WRITE: wdata_ready=1. RAM strobes are combinational: ram_en=wdata_valid, ram_wr_rdn=1, ram_addr=counter, ram_data_wr=wdata. Each handshake increments the address and decrements the beat count. The handshake on the last beat moves to DONE.
- READ: ram_en=1 and ram_wr_rdn=0 when issued<total and (skid occupancy + in-flight) < 2. An in-flight flag sets on issue. ram_data_rd is pushed into a 2-entry skid FIFO the next cycle. rdata/rdata_valid present the FIFO head. The pop of the last beat moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Beat count is an unsigned LEN_WIDTH value; cmd_len=0 means one beat.
- ram_en is never high outside WRITE/READ. ram_wr_rdn is 0 except in WRITE.
- wdata_valid outside WRITE and cmd_valid while busy are ignored, and no state changes.
- rst at any point: return to IDLE, flush the skid FIFO, and drop any in-flight read. ram_en is 0 during the rst cycle.

## Timing
- Reset values: cmd_ready=1 (IDLE), wdata_ready=0, rdata_valid=0, rdata=0, busy=0, done=0, err=0, ram_en=0, ram_wr_rdn=0, ram_addr=0, ram_data_wr=0.
- Command handshake in cycle T means WRITE or READ in T+1.
- Write: one beat per cycle. Last handshake in cycle W means done in W+1 and cmd_ready in W+2.
- Read: the first strobe is in T+1 and the first rdata_valid is in T+2. With rdata_ready held high, there is one beat per cycle. Last pop in cycle R means done in R+1.
- A stalled consumer stops strobes. No beat is lost or duplicated.

## Configuration
- RAM_BURST_MASTER_BOUND_EN defined: a command with cmd_addr+cmd_len > 2^ADDR_WIDTH-1 is accepted and moves to DONE, with err=1 and done=1 together in T+1. It issues no RAM strobe and consumes no write data.
- RAM_BURST_MASTER_BOUND_EN not defined: the address wraps to 0 and err is tied to 0.

## Structure
- Shared package ram_burst_pkg holds the state enum (IDLE, WRITE, READ, DONE) and the skid depth constant (2).
- Sub-module ram_rd_skid: a 2-entry FIFO with valid/ready output, occupancy count output, and synchronous flush.

## Test plan
- Reset: assert rst 2 cycles, then check every output against its reset value; cmd_ready=1.
- Write addr 0x010, len 3, data 0xA0..0xA3, wdata_valid held high: ram_en high for 4 consecutive cycles at addr 0x010..0x013 with ram_wr_rdn=1, then done one cycle later.
- Read addr 0x010, len 3, rdata_ready=1: rdata 0xA0..0xA3 on 4 consecutive cycles starting T+2, then done.
- Same read with rdata_ready toggling 1,0,1,0: all four beats arrive in order with none duplicated, and occupancy + in-flight never exceeds 2.
- Addr 0x3FE, len 3, write: with the macro, err and done pulse and ram_en stays 0. Without the macro, addresses are 0x3FE, 0x3FF, 0x000, 0x001.
- rst after the 2nd read beat of a 4-beat burst: next cycle rdata_valid=0, ram_en=0, cmd_ready=1. A following read returns correct data.
